// File: rtl/gate_bist_pkg.sv
// gate_bist_pkg
// Shared definitions for the two-input gate self-test controller:
//   - state_t       : controller FSM state encoding
//   - NUM_VECTORS   : number of input vectors applied per run
//   - *_TT          : expected truth tables, bit index = {a,b}
//   - vec_last      : helper flagging the final vector of a run
package gate_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int unsigned NUM_VECTORS = 4;

  localparam logic [3:0] OR_TT   = 4'b1110;
  localparam logic [3:0] AND_TT  = 4'b1000;
  localparam logic [3:0] NAND_TT = 4'b0111;
  localparam logic [3:0] NOR_TT  = 4'b0001;
  localparam logic [3:0] XOR_TT  = 4'b0110;

  function automatic logic vec_last(input logic [1:0] vec);
    return vec == 2'(NUM_VECTORS - 1);
  endfunction

endpackage

// File: rtl/gate_bist_timer.sv
// gate_bist_timer
// Settle-time counter. Counts while en is high, restarts from 0 on clear,
// and flags expire in the cycle where the count reaches SETTLE_CYCLES-1,
// i.e. in the last of SETTLE_CYCLES enabled cycles.
// Ports:
//   clk    in  clock, rising edge
//   rst    in  synchronous active-high reset
//   clear  in  restart count at 0 on the next edge
//   en     in  advance count on the next edge
//   expire out count == SETTLE_CYCLES-1 (combinational)
module gate_bist_timer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

  logic [3:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= 4'd0;
    end else if (en) begin
      count_q <= count_q + 4'd1;
    end
  end

  assign expire = (count_q == LAST);

endmodule

// File: rtl/gate_bist_ctrl.sv
// gate_bist_ctrl
// Self-test controller for a two-input logic gate. On start it applies the
// vectors 00, 01, 10, 11 to the gate, holds each one SETTLE_CYCLES cycles,
// then compares dut_y with the captured truth table and accumulates results.
//
// Handshake: start is a level sampled on the rising edge; it is accepted only
// in IDLE and ignored otherwise (no queueing). done is a one-cycle pulse in
// the DONE state; results are final in that cycle and held until the next
// accepted start.
//
// Ports:
//   clk, rst    clock / synchronous active-high reset
//   start       begin a run (IDLE only)
//   exp_tt[3:0] expected gate output indexed by {a,b}, captured at start
//   dut_y       gate output under test
//   dut_a/dut_b gate inputs
//   busy        run in progress (SETTLE/SAMPLE)
//   done        end-of-run pulse
//   pass        last run had no mismatches
//   err_cnt     mismatch count of last run
//   fail_vec    {a,b} of the first mismatch
//   dbg_state   current FSM state
//
// Build option: GATE_BIST_STOP_ON_FAIL_EN ends the run at the first mismatch.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] exp_tt,
  input  logic       dut_y,
  output logic       dut_a,
  output logic       dut_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [1:0] fail_vec,
  output logic [1:0] dbg_state
);

`ifdef GATE_BIST_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  state_t     state_q, state_d;
  logic [3:0] tt_q;
  logic [1:0] vec_q;
  logic [1:0] ab_q;
  logic [2:0] err_q;
  logic [2:0] err_next;
  logic       pass_q;
  logic [1:0] fail_q;

  logic       timer_clear;
  logic       timer_en;
  logic       timer_expire;
  logic       mismatch;

  gate_bist_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .en    (timer_en),
    .expire(timer_expire)
  );

  // Case inequality so that an x/z gate output is reported as a mismatch.
  assign mismatch = (dut_y !== tt_q[vec_q]);
  assign err_next = err_q + {2'b00, mismatch};

  always_comb begin
    state_d     = state_q;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_SETTLE;
          timer_clear = 1'b1;
        end
      end
      ST_SETTLE: begin
        timer_en = 1'b1;
        if (timer_expire) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        timer_clear = 1'b1;
        if (vec_last(vec_q) || (STOP_ON_FAIL && mismatch)) state_d = ST_DONE;
        else                                                 state_d = ST_SETTLE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tt_q    <= 4'd0;
      vec_q   <= 2'd0;
      ab_q    <= 2'd0;
      err_q   <= 3'd0;
      pass_q  <= 1'b0;
      fail_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            tt_q   <= exp_tt;
            vec_q  <= 2'd0;
            ab_q   <= 2'd0;
            err_q  <= 3'd0;
            pass_q <= 1'b0;
            fail_q <= 2'd0;
          end
        end
        ST_SAMPLE: begin
          err_q <= err_next;
          if (mismatch && (err_q == 3'd0)) fail_q <= vec_q;
          if (state_d == ST_DONE) begin
            // Results are registered on entry so they are final in the done cycle.
            pass_q <= (err_next == 3'd0);
            ab_q   <= 2'd0;
          end else begin
            vec_q <= vec_q + 2'd1;
            ab_q  <= vec_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dut_a     = ab_q[1];
  assign dut_b     = ab_q[0];
  assign busy      = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign err_cnt   = err_q;
  assign fail_vec  = fail_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// tb_gate_bist_ctrl
// Drives gate_bist_ctrl against a behavioural gate model (any 4-bit function,
// optionally floating during vector 10) and checks cycle-by-cycle outputs
// against expectations derived from the truth-table difference.
module tb_gate_bist_ctrl;
  import gate_bist_pkg::*;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] exp_tt;
  logic       dut_y;
  logic       dut_a, dut_b, busy, done, pass;
  logic [2:0] err_cnt;
  logic [1:0] fail_vec;
  logic [1:0] dbg_state;

  logic [3:0] g_tt;
  logic       z_on;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gate_bist_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .exp_tt   (exp_tt),
    .dut_y    (dut_y),
    .dut_a    (dut_a),
    .dut_b    (dut_b),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_cnt  (err_cnt),
    .fail_vec (fail_vec),
    .dbg_state(dbg_state)
  );

  // Gate under test: arbitrary function table, may float on input 10.
  always_comb begin
    if (z_on && {dut_a, dut_b} == 2'b10) dut_y = 1'bz;
    else                                 dut_y = g_tt[{dut_a, dut_b}];
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One run. glitch: exp_tt -> 0 from cycle 4 and start re-pulsed in cycle 5.
  // rst_at > 0: reset asserted during that cycle, run abandoned.
  task automatic run_test(input string name, input logic [3:0] expv, input logic [3:0] gtt,
                          input bit zmode, input bit glitch, input int rst_at);
    bit mism[4];
    int nerr, first, done_cyc, last_cyc;
    nerr  = 0;
    first = -1;
    for (int i = 0; i < 4; i++) begin
      mism[i] = (gtt[i] != expv[i]) || (zmode && i == 2);
      if (mism[i]) begin
        nerr++;
        if (first < 0) first = i;
      end
    end
`ifdef GATE_BIST_STOP_ON_FAIL_EN
    if (first >= 0) begin
      nerr     = 1;
      done_cyc = (first + 1) * (S + 1) + 1;
    end else begin
      done_cyc = NUM_VECTORS * (S + 1) + 1;
    end
`else
    done_cyc = NUM_VECTORS * (S + 1) + 1;
`endif
    last_cyc = (rst_at > 0) ? rst_at + 8 : done_cyc;

    @(negedge clk);
    g_tt   = gtt;
    z_on   = zmode;
    exp_tt = expv;
    start  = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= last_cyc; cyc++) begin
      @(negedge clk);
      start = (glitch && cyc == 5);
      rst   = (rst_at == cyc);
      if (glitch && cyc >= 4) exp_tt = 4'd0;
      if (rst_at > 0 && cyc > rst_at) begin
        chk({name, " rst done"}, 8'(done), 8'd0);
        chk({name, " rst busy"}, 8'(busy), 8'd0);
        chk({name, " rst ab"}, 8'({dut_a, dut_b}), 8'd0);
        if (cyc == rst_at + 1) begin
          chk({name, " rst state"}, 8'(dbg_state), 8'(ST_IDLE));
          chk({name, " rst err"}, 8'(err_cnt), 8'd0);
        end
      end else if (cyc == done_cyc) begin
        chk({name, " done"}, 8'(done), 8'd1);
        chk({name, " busy@done"}, 8'(busy), 8'd0);
        chk({name, " err_cnt"}, 8'(err_cnt), 8'(nerr));
        chk({name, " pass"}, 8'(pass), 8'(nerr == 0));
        if (nerr != 0) chk({name, " fail_vec"}, 8'(fail_vec), 8'(first));
      end else begin
        chk({name, " no done"}, 8'(done), 8'd0);
        chk({name, " busy"}, 8'(busy), 8'd1);
        chk({name, " vector"}, 8'({dut_a, dut_b}), 8'((cyc - 1) / (S + 1)));
      end
    end
    if (rst_at == 0) begin
      @(negedge clk);
      start = 1'b0;
      chk({name, " post done"}, 8'(done), 8'd0);
      chk({name, " post busy"}, 8'(busy), 8'd0);
      chk({name, " post ab"}, 8'({dut_a, dut_b}), 8'd0);
      chk({name, " post state"}, 8'(dbg_state), 8'(ST_IDLE));
      chk({name, " hold err"}, 8'(err_cnt), 8'(nerr));
      chk({name, " hold pass"}, 8'(pass), 8'(nerr == 0));
    end
    rst   = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    exp_tt = 4'd0;
    g_tt   = OR_TT;
    z_on   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset state", 8'(dbg_state), 8'(ST_IDLE));
    chk("reset ab", 8'({dut_a, dut_b}), 8'd0);
    chk("reset busy", 8'(busy), 8'd0);
    chk("reset done", 8'(done), 8'd0);
    chk("reset pass", 8'(pass), 8'd0);
    chk("reset err", 8'(err_cnt), 8'd0);
    chk("reset fail_vec", 8'(fail_vec), 8'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle no start", 8'(dbg_state), 8'(ST_IDLE));

    run_test("good_or", OR_TT, OR_TT, 1'b0, 1'b0, 0);
    run_test("stuck0", 4'b1110, 4'b0000, 1'b0, 1'b0, 0);
    run_test("or_vs_and", AND_TT, OR_TT, 1'b0, 1'b0, 0);
    run_test("glitch", OR_TT, OR_TT, 1'b0, 1'b1, 0);
    run_test("reset_mid", OR_TT, OR_TT, 1'b0, 1'b0, 5);
    run_test("after_rst", OR_TT, OR_TT, 1'b0, 1'b0, 0);
    run_test("z_on_10", OR_TT, OR_TT, 1'b1, 1'b0, 0);
    run_test("good_xor", XOR_TT, XOR_TT, 1'b0, 1'b0, 0);
    run_test("nand_vs_nor", NOR_TT, NAND_TT, 1'b0, 1'b0, 0);
    for (int k = 0; k < 8; k++) begin
      logic [3:0] re, rg;
      re = 4'($urandom_range(0, 15));
      rg = 4'($urandom_range(0, 15));
      run_test("random", re, rg, 1'b0, 1'b0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
